// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types for the memory-port arbiter that puts the core's instruction
// fetch (I) and load/store (D) ports onto the single MMU bus.
//   arb_state_t     : arbiter FSM state (idle, serving I, serving D)
//   mem_cmd_t       : one registered bus command (we, addr, wdata, wmask)
//   starveCntWidth  : width of the starvation counter for a given limit
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } mem_cmd_t;

    localparam mem_cmd_t MEM_CMD_RESET = '0;

    // A limit of 0 disables the counter, but a zero-width vector is illegal,
    // so the counter is never narrower than one bit.
    function automatic int starveCntWidth(input int limit);
        return (limit > 0) ? $clog2(limit + 1) : 1;
    endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// ---------------------------------------------------------------------------
// arb_starve_counter
// Saturating count of arbitration rounds the fetch port has lost in a row.
// Ports:
//   clk        in  core clock
//   rst        in  asynchronous, active-high reset
//   inc_i      in  fetch lost an arbitration round this cycle
//   clr_i      in  fetch was granted this cycle (takes priority over inc_i)
//   at_limit_o out count has reached LIMIT; always 0 when LIMIT is 0
// Parameter LIMIT: saturation value; 0 disables the counter entirely.
// ---------------------------------------------------------------------------
module arb_starve_counter
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic at_limit_o
);

    localparam int            CW      = starveCntWidth(LIMIT);
    localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Saturation is checked with an inequality against the limit so that a
    // zero limit simply freezes the counter at zero.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != LIMIT_C)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // The counter never exceeds the limit, so equality is the same as >=.
    assign at_limit_o = (LIMIT != 0) && (count_q == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single MMU bus between the instruction-fetch (I) and load/store
// (D) ports of the core, one transaction in flight at a time. D normally wins,
// but after STARVE_LIMIT lost rounds I is forced a grant (0 = strict D first).
// Ports:
//   clk, rst                      core clock, asynchronous active-high reset
//   i_req/i_addr                  fetch request, held until i_ack
//   i_rdata/i_ack                 fetch read data and one-cycle completion
//   d_req/d_we/d_addr/d_wdata/d_wmask  load/store request, held until d_ack
//   d_rdata/d_ack                 load data and one-cycle completion
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wmask  registered bus command
//   mem_rdata/mem_ack             bus read data and completion
// Build option ARB_PERF_EN adds perf_i_grants, perf_d_grants and perf_i_stall
// (CNT_W bits, wrapping) counting grants and fetch stall cycles.
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
`ifdef ARB_PERF_EN
    ,
    parameter int CNT_W        = 32
`endif
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_wmask,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
`ifdef ARB_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_i_grants,
    output logic [CNT_W-1:0] perf_d_grants,
    output logic [CNT_W-1:0] perf_i_stall
`endif
);

    arb_state_t state_q;
    arb_state_t state_d;
    mem_cmd_t   cmd_q;
    mem_cmd_t   cmd_d;

    logic grantI;
    logic grantD;
    logic starveAtLimit;

    // Arbitration only happens in IDLE. A starved fetch beats a pending data
    // access; otherwise data has priority over fetch.
    always_comb begin
        grantI = 1'b0;
        grantD = 1'b0;
        if (state_q == ARB_IDLE) begin
            if (i_req && starveAtLimit) begin
                grantI = 1'b1;
            end else if (d_req) begin
                grantD = 1'b1;
            end else if (i_req) begin
                grantI = 1'b1;
            end
        end
    end

    // A grant captures the winner's fields; they then stay frozen on the bus
    // until mem_ack. Fetches are always reads with no byte enables, while
    // loads pass d_wmask through untouched.
    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        case (state_q)
            ARB_IDLE: begin
                if (grantI) begin
                    state_d     = ARB_BUSY_I;
                    cmd_d.we    = 1'b0;
                    cmd_d.addr  = i_addr;
                    cmd_d.wdata = '0;
                    cmd_d.wmask = '0;
                end else if (grantD) begin
                    state_d     = ARB_BUSY_D;
                    cmd_d.we    = d_we;
                    cmd_d.addr  = d_addr;
                    cmd_d.wdata = d_wdata;
                    cmd_d.wmask = d_wmask;
                end
            end
            ARB_BUSY_I, ARB_BUSY_D: begin
                if (mem_ack) begin
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Reset abandons any in-flight access immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            cmd_q   <= MEM_CMD_RESET;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
        end
    end

    // Fetch loses a round only when it was actually asking and D won.
    arb_starve_counter #(
        .LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .inc_i     (grantD && i_req),
        .clr_i     (grantI),
        .at_limit_o(starveAtLimit)
    );

    assign mem_req   = (state_q != ARB_IDLE);
    assign mem_we    = cmd_q.we;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;
    assign mem_wmask = cmd_q.wmask;

    // Acks are combinational so the requester sees completion in the same
    // cycle as the bus; an ack arriving while idle is dropped.
    assign i_ack   = (state_q == ARB_BUSY_I) && mem_ack;
    assign d_ack   = (state_q == ARB_BUSY_D) && mem_ack;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

`ifdef ARB_PERF_EN
    logic [CNT_W-1:0] perf_i_grants_q;
    logic [CNT_W-1:0] perf_d_grants_q;
    logic [CNT_W-1:0] perf_i_stall_q;

    // Free-running counters that wrap naturally at 2^CNT_W.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_i_grants_q <= '0;
            perf_d_grants_q <= '0;
            perf_i_stall_q  <= '0;
        end else begin
            if (grantI) begin
                perf_i_grants_q <= perf_i_grants_q + 1'b1;
            end
            if (grantD) begin
                perf_d_grants_q <= perf_d_grants_q + 1'b1;
            end
            if (i_req && !i_ack) begin
                perf_i_stall_q <= perf_i_stall_q + 1'b1;
            end
        end
    end

    assign perf_i_grants = perf_i_grants_q;
    assign perf_d_grants = perf_d_grants_q;
    assign perf_i_stall  = perf_i_stall_q;
`endif

`ifdef SIMULATION
    // Requesters must hold their request through the ack cycle; the bus
    // transaction is completed regardless.
    assert property (@(posedge clk) disable iff (rst) (state_q == ARB_BUSY_I) |-> i_req)
        else $error("mem_port_arbiter: i_req dropped before i_ack");
    assert property (@(posedge clk) disable iff (rst) (state_q == ARB_BUSY_D) |-> d_req)
        else $error("mem_port_arbiter: d_req dropped before d_ack");
    // A stray ack while idle is tolerated and ignored, but worth flagging.
    assert property (@(posedge clk) disable iff (rst) (state_q == ARB_IDLE) |-> !mem_ack)
        else $warning("mem_port_arbiter: mem_ack received while idle");
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter. Instance dut uses STARVE_LIMIT=4;
// instance dut0 uses STARVE_LIMIT=0 (strict data priority). The perf counter
// scenario is compiled in when ARB_PERF_EN is defined.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    logic        i_req0;
    logic        d_req0;
    logic        mem_ack0;
    logic [31:0] i_rdata0;
    logic        i_ack0;
    logic [31:0] d_rdata0;
    logic        d_ack0;
    logic        mem_req0;
    logic        mem_we0;
    logic [31:0] mem_addr0;
    logic [31:0] mem_wdata0;
    logic [3:0]  mem_wmask0;

`ifdef ARB_PERF_EN
    logic [31:0] perfIGrants;
    logic [31:0] perfDGrants;
    logic [31:0] perfIStall;
    logic [31:0] perfIGrants0;
    logic [31:0] perfDGrants0;
    logic [31:0] perfIStall0;
`endif

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_ack    (i_ack),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_wmask  (d_wmask),
        .d_rdata  (d_rdata),
        .d_ack    (d_ack),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
`ifdef ARB_PERF_EN
        ,
        .perf_i_grants(perfIGrants),
        .perf_d_grants(perfDGrants),
        .perf_i_stall (perfIStall)
`endif
    );

    mem_port_arbiter #(.STARVE_LIMIT(0)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .i_req    (i_req0),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata0),
        .i_ack    (i_ack0),
        .d_req    (d_req0),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_wmask  (d_wmask),
        .d_rdata  (d_rdata0),
        .d_ack    (d_ack0),
        .mem_req  (mem_req0),
        .mem_we   (mem_we0),
        .mem_addr (mem_addr0),
        .mem_wdata(mem_wdata0),
        .mem_wmask(mem_wmask0),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack0)
`ifdef ARB_PERF_EN
        ,
        .perf_i_grants(perfIGrants0),
        .perf_d_grants(perfDGrants0),
        .perf_i_stall (perfIStall0)
`endif
    );

    // Reset values, then a single fetch with a 3-cycle bus latency.
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_req: got %0b expected 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_we: got %0b expected 0", mem_we); end
        checks++; if (mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        checks++; if (mem_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
        checks++; if (mem_wmask !== 4'h0) begin errors++; $display("[TB] FAIL reset_mem_wmask: got %h expected 0", mem_wmask); end
        checks++; if (i_ack !== 1'b0 || d_ack !== 1'b0) begin errors++; $display("[TB] FAIL reset_acks: got i=%0b d=%0b expected 0 0", i_ack, d_ack); end

        rst    = 1'b0;
        i_req  = 1'b1;
        i_addr = 32'h0000_0000;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL fetch_grant_latency: got mem_req=%0b expected 1", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("[TB] FAIL fetch_we: got %0b expected 0", mem_we); end
        repeat (2) begin
            @(negedge clk);
            checks++; if (mem_req !== 1'b1 || i_ack !== 1'b0) begin errors++; $display("[TB] FAIL fetch_hold: got mem_req=%0b i_ack=%0b expected 1 0", mem_req, i_ack); end
        end
        mem_rdata = 32'hA5A5_0001;
        mem_ack   = 1'b1;
        #1;
        checks++; if (i_ack !== 1'b1) begin errors++; $display("[TB] FAIL fetch_ack: got %0b expected 1", i_ack); end
        checks++; if (i_rdata !== 32'hA5A5_0001) begin errors++; $display("[TB] FAIL fetch_rdata: got %h expected a5a50001", i_rdata); end
        checks++; if (d_ack !== 1'b0) begin errors++; $display("[TB] FAIL fetch_no_dack: got %0b expected 0", d_ack); end
        @(negedge clk);
        mem_ack = 1'b0;
        i_req   = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || i_ack !== 1'b0) begin errors++; $display("[TB] FAIL fetch_done: got mem_req=%0b i_ack=%0b expected 0 0", mem_req, i_ack); end
    endtask

    // Fetch and store requested together: the store goes first, the fetch
    // follows after one idle bubble.
    task automatic test_simultaneous();
        i_req   = 1'b1;
        i_addr  = 32'h0000_0040;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h1000_0000;
        d_wdata = 32'hDEAD_BEEF;
        d_wmask = 4'b0011;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("[TB] FAIL sim_d_grant: got req=%0b we=%0b expected 1 1", mem_req, mem_we); end
        checks++; if (mem_addr !== 32'h1000_0000) begin errors++; $display("[TB] FAIL sim_d_addr: got %h expected 10000000", mem_addr); end
        checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL sim_d_wdata: got %h expected deadbeef", mem_wdata); end
        checks++; if (mem_wmask !== 4'b0011) begin errors++; $display("[TB] FAIL sim_d_wmask: got %b expected 0011", mem_wmask); end
        mem_ack   = 1'b1;
        mem_rdata = 32'h0;
        #1;
        checks++; if (d_ack !== 1'b1 || i_ack !== 1'b0) begin errors++; $display("[TB] FAIL sim_d_ack: got d=%0b i=%0b expected 1 0", d_ack, i_ack); end
        @(negedge clk);
        mem_ack = 1'b0;
        d_req   = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL sim_bubble: got mem_req=%0b expected 0", mem_req); end
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("[TB] FAIL sim_i_grant: got req=%0b we=%0b expected 1 0", mem_req, mem_we); end
        checks++; if (mem_addr !== 32'h0000_0040 || mem_wmask !== 4'b0000) begin errors++; $display("[TB] FAIL sim_i_fields: got addr=%h wmask=%b expected 00000040 0000", mem_addr, mem_wmask); end
        mem_ack   = 1'b1;
        mem_rdata = 32'h1357_9BDF;
        #1;
        checks++; if (i_ack !== 1'b1 || i_rdata !== 32'h1357_9BDF) begin errors++; $display("[TB] FAIL sim_i_ack: got ack=%0b rdata=%h expected 1 13579bdf", i_ack, i_rdata); end
        @(negedge clk);
        mem_ack = 1'b0;
        i_req   = 1'b0;
    endtask

    // Both requests held: D wins four rounds, I takes the fifth, and with the
    // counter cleared D wins again afterwards.
    task automatic test_starvation();
        logic [6:0] expI;
        logic       isI;
        expI    = 7'b001_0000;
        i_req   = 1'b1;
        i_addr  = 32'h0000_0080;
        d_req   = 1'b1;
        d_we    = 1'b0;
        d_addr  = 32'h2000_0000;
        d_wdata = 32'h0;
        d_wmask = 4'b1111;
        for (int t = 0; t < 7; t++) begin
            int w;
            w = 0;
            @(negedge clk);
            while (!mem_req && w < 10) begin
                @(negedge clk);
                w++;
            end
            checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL starve_timeout: round %0d got mem_req=%0b expected 1", t, mem_req); end
            isI = (mem_addr == 32'h0000_0080);
            checks++; if (isI !== expI[t]) begin errors++; $display("[TB] FAIL starve_winner: round %0d got isI=%0b expected %0b", t, isI, expI[t]); end
            if (!isI) begin
                checks++; if (mem_we !== 1'b0 || mem_wmask !== 4'b1111) begin errors++; $display("[TB] FAIL starve_load_fields: got we=%0b wmask=%b expected 0 1111", mem_we, mem_wmask); end
            end
            mem_ack   = 1'b1;
            mem_rdata = 32'h5000 + t;
            #1;
            checks++; if (i_ack !== expI[t] || d_ack !== !expI[t]) begin errors++; $display("[TB] FAIL starve_ack: round %0d got i=%0b d=%0b expected %0b %0b", t, i_ack, d_ack, expI[t], !expI[t]); end
            @(negedge clk);
            mem_ack = 1'b0;
        end
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    // Strict data priority: with D always requesting, fetch is never served.
    task automatic test_no_starve_limit0();
        int iAcks;
        int dAcks;
        iAcks  = 0;
        dAcks  = 0;
        i_req0 = 1'b1;
        d_req0 = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h2000_0100;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            mem_ack0 = mem_req0 && !mem_ack0;
            #1;
            if (i_ack0) iAcks++;
            if (d_ack0) dAcks++;
        end
        i_req0   = 1'b0;
        d_req0   = 1'b0;
        mem_ack0 = 1'b0;
        checks++; if (iAcks != 0) begin errors++; $display("[TB] FAIL limit0_i_ack: got %0d acks expected 0", iAcks); end
        checks++; if (dAcks != 25) begin errors++; $display("[TB] FAIL limit0_d_ack: got %0d acks expected 25", dAcks); end
    endtask

    // Reset in the middle of a store abandons it; a late ack does nothing.
    task automatic test_reset_midop();
        @(negedge clk);
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h3000_0010;
        d_wdata = 32'h0BAD_F00D;
        d_wmask = 4'b1111;
        @(negedge clk);
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h3000_0010) begin errors++; $display("[TB] FAIL midop_grant: got req=%0b addr=%h expected 1 30000010", mem_req, mem_addr); end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL midop_req_clear: got %0b expected 0", mem_req); end
        checks++; if (d_ack !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("[TB] FAIL midop_state: got d_ack=%0b addr=%h expected 0 0", d_ack, mem_addr); end
        d_req = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF_0000;
        #1;
        checks++; if (d_ack !== 1'b0 || i_ack !== 1'b0) begin errors++; $display("[TB] FAIL midop_late_ack: got d=%0b i=%0b expected 0 0", d_ack, i_ack); end
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL midop_idle: got mem_req=%0b expected 0", mem_req); end
    endtask

`ifdef ARB_PERF_EN
    // Three fetches and two stores, each with a 2-cycle bus latency. Every
    // fetch is stalled on its grant cycle and the following wait cycle, and
    // completes on the third, so the expected stall count is 3 * 2 = 6.
    task automatic test_perf();
        logic [4:0] kinds;
        kinds = 5'b10101;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (perfIGrants !== 32'd0 || perfDGrants !== 32'd0 || perfIStall !== 32'd0) begin errors++; $display("[TB] FAIL perf_reset: got %0d %0d %0d expected 0 0 0", perfIGrants, perfDGrants, perfIStall); end
        for (int n = 0; n < 5; n++) begin
            int w;
            if (kinds[n]) begin
                i_req  = 1'b1;
                i_addr = 32'h0000_1000 + 32'(n * 4);
            end else begin
                d_req   = 1'b1;
                d_we    = 1'b1;
                d_addr  = 32'h4000_0000 + 32'(n * 4);
                d_wdata = 32'(n);
                d_wmask = 4'b1111;
            end
            w = 0;
            @(negedge clk);
            while (!mem_req && w < 10) begin
                @(negedge clk);
                w++;
            end
            checks++; if (mem_req !== 1'b1) begin errors++; $display("[TB] FAIL perf_timeout: xfer %0d got mem_req=%0b expected 1", n, mem_req); end
            @(negedge clk);
            mem_ack = 1'b1;
            @(negedge clk);
            mem_ack = 1'b0;
            i_req   = 1'b0;
            d_req   = 1'b0;
        end
        checks++; if (perfIGrants !== 32'd3) begin errors++; $display("[TB] FAIL perf_i_grants: got %0d expected 3", perfIGrants); end
        checks++; if (perfDGrants !== 32'd2) begin errors++; $display("[TB] FAIL perf_d_grants: got %0d expected 2", perfDGrants); end
        checks++; if (perfIStall !== 32'd6) begin errors++; $display("[TB] FAIL perf_i_stall: got %0d expected 6", perfIStall); end
    endtask
`endif

    // Guard against a hung handshake.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        i_req     = 1'b0;
        i_addr    = 32'h0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = 32'h0;
        d_wdata   = 32'h0;
        d_wmask   = 4'h0;
        mem_rdata = 32'h0;
        mem_ack   = 1'b0;
        i_req0    = 1'b0;
        d_req0    = 1'b0;
        mem_ack0  = 1'b0;

        test_reset();
        test_simultaneous();
        test_starvation();
        test_no_starve_limit0();
        test_reset_midop();
`ifdef ARB_PERF_EN
        test_perf();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
